// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU controller.
// Opcode and phase encodings used by the sequencer and its decoder.
package cpu_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational strobe decode from phase, opcode, zero flag and halt state.
// Once halted, only halt is driven high.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  phase_t  phase,
  input  opcode_t opcode,
  input  logic    zero,
  input  logic    halted,
  output logic    sel,
  output logic    rd,
  output logic    ld_ir,
  output logic    inc_pc,
  output logic    ld_pc,
  output logic    ld_ac,
  output logic    wr,
  output logic    data_e,
  output logic    halt
);

  logic alu_op;
  logic is_sto;
  logic is_jmp;

  assign alu_op = opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      unique case (phase)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: begin
          rd = alu_op;
        end
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = alu_op;
          inc_pc = is_jmp;
          ld_pc  = is_jmp;
          ld_ac  = alu_op;
          wr     = is_sto;
          data_e = is_sto;
        end
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer: phase register, sticky halt,
// saturating retired-instruction counter and strobe decode.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int OPCODE_W    = 3,
  parameter int INSTR_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [OPCODE_W-1:0]    opcode,
  input  logic                   zero,
  output logic                   sel,
  output logic                   rd,
  output logic                   ld_ir,
  output logic                   inc_pc,
  output logic                   ld_pc,
  output logic                   ld_ac,
  output logic                   wr,
  output logic                   data_e,
  output logic                   halt,
  output logic [2:0]             phase,
  output logic [INSTR_CNT_W-1:0] instr_cnt
);

  if (OPCODE_W != 3) begin : g_bad_w
    $error("cpu_controller: OPCODE_W must be 3");
  end

  phase_t                 phase_q;
  logic                   halted_q;
  logic [INSTR_CNT_W-1:0] cnt_q;
  opcode_t                op;

  assign op = opcode_t'(opcode[2:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else if (run && !halted_q) begin
      if (phase_q == OP_ADDR && op == OP_HLT) begin
        halted_q <= 1'b1;
      end else begin
        phase_q <= phase_t'(phase_q + 3'd1);
        if (phase_q == STORE && cnt_q != '1)
          cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign phase     = phase_q;
  assign instr_cnt = cnt_q;

  cpu_ctrl_decode u_decode (
    .phase  (phase_q),
    .opcode (op),
    .zero   (zero),
    .halted (halted_q),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: per-cycle model check plus directed
// literal checks; a narrow-counter instance exercises saturation.
module tb_cpu_controller;

  logic clk;
  logic rst_n;
  logic run;
  logic [2:0] opcode;
  logic zero;

  logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;
  logic [15:0] instr_cnt;

  logic s_sel, s_rd, s_ld_ir, s_inc_pc, s_ld_pc;
  logic s_ld_ac, s_wr, s_data_e, s_halt;
  logic [2:0] s_phase;
  logic [2:0] s_cnt;

  cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir),
    .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ac(ld_ac),
    .wr(wr), .data_e(data_e), .halt(halt),
    .phase(phase), .instr_cnt(instr_cnt)
  );

  cpu_controller #(.INSTR_CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .run(run),
    .opcode(opcode), .zero(zero),
    .sel(s_sel), .rd(s_rd), .ld_ir(s_ld_ir),
    .inc_pc(s_inc_pc), .ld_pc(s_ld_pc), .ld_ac(s_ld_ac),
    .wr(s_wr), .data_e(s_data_e), .halt(s_halt),
    .phase(s_phase), .instr_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase index, halt flag, retired count
  int m_ph = 0;
  bit m_halted = 0;
  int m_ret = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph     <= 0;
      m_halted <= 0;
      m_ret    <= 0;
      m_valid  <= 1;
    end else if (run && !m_halted) begin
      if (m_ph == 4 && opcode == 3'd0) begin
        m_halted <= 1;
      end else begin
        if (m_ph == 7) m_ret <= m_ret + 1;
        m_ph <= (m_ph + 1) % 8;
      end
    end
  end

  // Order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
  function automatic logic [8:0] exp_strobes(int ph, bit h, int op, bit z);
    bit alu;
    logic [8:0] v;
    alu = (op >= 2 && op <= 5);
    if (h) return 9'b0_0000_0001;
    v[8] = (ph <= 3);
    v[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    v[6] = (ph == 2 || ph == 3);
    v[5] = (ph == 4) || (ph == 6 && op == 1 && z) || (ph == 7 && op == 7);
    v[4] = (ph >= 6 && op == 7);
    v[3] = (ph == 7 && alu);
    v[2] = (ph == 7 && op == 6);
    v[1] = (ph >= 6 && op == 6);
    v[0] = (ph == 4 && op == 0);
    return v;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      logic [8:0] e;
      e = exp_strobes(m_ph, m_halted, int'(opcode), zero);
      chk("strobes",
          {23'd0, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt},
          {23'd0, e});
      chk("phase", {29'd0, phase}, m_ph);
      chk("instr_cnt", {16'd0, instr_cnt},
          (m_ret > 65535) ? 65535 : m_ret);
      chk("sat_cnt", {29'd0, s_cnt}, (m_ret > 7) ? 7 : m_ret);
      chk("sat_strobes",
          {23'd0, s_sel, s_rd, s_ld_ir, s_inc_pc, s_ld_pc,
           s_ld_ac, s_wr, s_data_e, s_halt},
          {23'd0, e});
      chk("sat_phase", {29'd0, s_phase}, m_ph);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    run    = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;
    cyc(2);
    chk("rst_phase", {29'd0, phase}, 0);
    chk("rst_sel", {31'd0, sel}, 1);
    chk("rst_cnt", {16'd0, instr_cnt}, 0);

    rst_n = 1'b1;
    run   = 1'b1;
    cyc(7);
    chk("add_p7_phase", {29'd0, phase}, 7);
    chk("add_p7_ld_ac", {31'd0, ld_ac}, 1);
    cyc(1);
    chk("add_wrap_cnt", {16'd0, instr_cnt}, 1);

    opcode = 3'd1;
    zero   = 1'b1;
    cyc(4);
    chk("skz_p4_inc", {31'd0, inc_pc}, 1);
    cyc(2);
    chk("skz_z1_p6_inc", {31'd0, inc_pc}, 1);
    cyc(2);
    zero = 1'b0;
    cyc(6);
    chk("skz_z0_p6_inc", {31'd0, inc_pc}, 0);
    cyc(2);

    opcode = 3'd7;
    cyc(7);
    chk("jmp_p7_ld_pc", {31'd0, ld_pc}, 1);
    chk("jmp_p7_inc", {31'd0, inc_pc}, 1);
    chk("jmp_p7_rd", {31'd0, rd}, 0);
    cyc(1);

    opcode = 3'd6;
    cyc(7);
    chk("sto_p7_wr", {31'd0, wr}, 1);
    chk("sto_p7_data_e", {31'd0, data_e}, 1);
    chk("sto_p7_ld_ac", {31'd0, ld_ac}, 0);
    cyc(1);
    chk("cnt_after5", {16'd0, instr_cnt}, 5);

    opcode = 3'd2;
    cyc(72);
    chk("cnt_after14", {16'd0, instr_cnt}, 14);
    chk("sat_cnt_lit", {29'd0, s_cnt}, 7);

    cyc(5);
    chk("stall_pre", {29'd0, phase}, 5);
    run = 1'b0;
    cyc(3);
    chk("stall_hold", {29'd0, phase}, 5);
    run = 1'b1;
    cyc(1);
    chk("stall_resume", {29'd0, phase}, 6);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_phase", {29'd0, phase}, 0);
    chk("mid_rst_cnt", {16'd0, instr_cnt}, 0);
    rst_n = 1'b1;

    opcode = 3'd0;
    cyc(4);
    chk("hlt_p4_halt", {31'd0, halt}, 1);
    cyc(1);
    opcode = 3'd2;
    cyc(20);
    chk("hlt_phase", {29'd0, phase}, 4);
    chk("hlt_halt", {31'd0, halt}, 1);
    chk("hlt_inc", {31'd0, inc_pc}, 0);
    chk("hlt_cnt", {16'd0, instr_cnt}, 0);
    rst_n = 1'b0;
    cyc(1);
    chk("hlt_rst_phase", {29'd0, phase}, 0);
    chk("hlt_rst_halt", {31'd0, halt}, 0);
    rst_n = 1'b1;
    cyc(8);
    chk("post_hlt_cnt", {16'd0, instr_cnt}, 1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
